// File: rtl/mmu_bus_pkg.sv
// rtl/mmu_bus_pkg.sv - shared encodings, state enum and lane helper for mmu_bus_master
package mmu_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_GAP,
        ST_BEAT1,
        ST_RESP
    } state_t;

    // Right-aligned lane mask for an access size; encoding 3 behaves as a word.
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mmu_lane_gen.sv
// rtl/mmu_lane_gen.sv - byte lane strobes and write data for the two possible bus beats
//
// Ports:
//   offset  in  2  : byte offset within the word (addr[1:0])
//   size    in  2  : access size encoding
//   wdata   in 32  : right-aligned write data
//   strb0/1 out 4  : lane enables for beat 0 / beat 1
//   data0/1 out 32 : lane-shifted write data for beat 0 / beat 1, disabled lanes 0
//   split   out 1  : access spills into the next word and needs beat 1
module mmu_lane_gen
    import mmu_bus_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  strb0,
    output logic [3:0]  strb1,
    output logic [31:0] data0,
    output logic [31:0] data1,
    output logic        split
);

    logic [7:0]  lanes;
    logic [63:0] shifted;
    logic [63:0] lane_mask;

    // Treat the two beats as one 8-lane window: shifting by the offset puts
    // the overflow bytes straight into the beat 1 half.
    always_comb begin
        lane_mask = '0;
        lanes     = {4'b0000, size_lanes(size)} << offset;
        shifted   = {32'd0, wdata} << {offset, 3'b000};
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{lanes[i]}};
        end
        strb0 = lanes[3:0];
        strb1 = lanes[7:4];
        data0 = shifted[31:0]  & lane_mask[31:0];
        data1 = shifted[63:32] & lane_mask[63:32];
        split = |lanes[7:4];
    end

endmodule

// File: rtl/mmu_bus_master.sv
// rtl/mmu_bus_master.sv - CPU/MMU request to single-beat wish_bus master, with unaligned split and read merge
//
// Optional feature macro: MMU_BUS_TIMEOUT_EN (per-beat ack timeout, reports rsp_err).
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/ready/we/size   : request handshake and attributes
//   req_addr, req_wdata       : byte address and right-aligned write data
//   rsp_valid/rdata/err       : one-cycle completion pulse, merged read data, timeout flag
//   m_cyc/we/strb/addr/data_o : bus master outputs (all registered)
//   m_ack, m_data_i           : bus slave ack and read data
module mmu_bus_master
    import mmu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        m_cyc,
    output logic        m_we,
    output logic [3:0]  m_strb,
    output logic [31:0] m_addr,
    output logic [31:0] m_data_o,
    input  logic        m_ack,
    input  logic [31:0] m_data_i
);

    state_t      state, state_nxt;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r, rd0_r;
    logic        timeout;

    logic [1:0]  lane_off, lane_size;
    logic [31:0] lane_wdata;
    logic [3:0]  strb0, strb1;
    logic [31:0] data0, data1;
    logic        split;

    logic        m_cyc_nxt, m_we_nxt, rsp_valid_nxt;
    logic [3:0]  m_strb_nxt;
    logic [31:0] m_addr_nxt, m_data_nxt, rsp_rdata_nxt;

    logic [63:0] beats, beats_sh;
    logic [31:0] rmask, merged;
    logic [3:0]  rlanes;

    // In IDLE the lane generator looks at the live request so beat 0 can be
    // registered on the accepting edge; afterwards it looks at the captured copy.
    assign lane_off   = (state == ST_IDLE) ? req_addr[1:0] : addr_r[1:0];
    assign lane_size  = (state == ST_IDLE) ? req_size      : size_r;
    assign lane_wdata = (state == ST_IDLE) ? req_wdata     : wdata_r;

    mmu_lane_gen u_lane_gen (
        .offset (lane_off),
        .size   (lane_size),
        .wdata  (lane_wdata),
        .strb0  (strb0),
        .strb1  (strb1),
        .data0  (data0),
        .data1  (data1),
        .split  (split)
    );

    assign req_ready = (state == ST_IDLE);

    // Read merge: in BEAT0 the live bus word is beat 0; in BEAT1 beat 0 was
    // captured earlier. For unsplit accesses the upper half is masked off.
    always_comb begin
        rmask    = '0;
        beats    = {m_data_i, (state == ST_BEAT0) ? m_data_i : rd0_r};
        beats_sh = beats >> {addr_r[1:0], 3'b000};
        rlanes   = size_lanes(size_r);
        for (int i = 0; i < 4; i++) begin
            rmask[8*i +: 8] = {8{rlanes[i]}};
        end
        merged = beats_sh[31:0] & rmask;
    end

    always_comb begin
        state_nxt     = state;
        m_cyc_nxt     = m_cyc;
        m_we_nxt      = m_we;
        m_strb_nxt    = m_strb;
        m_addr_nxt    = m_addr;
        m_data_nxt    = m_data_o;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt  = ST_BEAT0;
                    m_cyc_nxt  = 1'b1;
                    m_we_nxt   = req_we;
                    m_strb_nxt = strb0;
                    m_addr_nxt = {req_addr[31:2], 2'b00};
                    m_data_nxt = data0;
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (m_ack && state == ST_BEAT0 && split) begin
                    state_nxt  = ST_GAP;
                    m_cyc_nxt  = 1'b0;
                    m_strb_nxt = strb1;
                    m_addr_nxt = m_addr + 32'd4;
                    m_data_nxt = data1;
                end else if (m_ack || timeout) begin
                    state_nxt     = ST_RESP;
                    m_cyc_nxt     = 1'b0;
                    m_we_nxt      = 1'b0;
                    m_strb_nxt    = '0;
                    m_addr_nxt    = '0;
                    m_data_nxt    = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = (m_ack && !m_we) ? merged : 32'd0;
                end
            end
            ST_GAP: begin
                state_nxt = ST_BEAT1;
                m_cyc_nxt = 1'b1;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r    <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rd0_r     <= '0;
            m_cyc     <= 1'b0;
            m_we      <= 1'b0;
            m_strb    <= '0;
            m_addr    <= '0;
            m_data_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                size_r  <= req_size;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (state == ST_BEAT0 && m_ack) begin
                rd0_r <= m_data_i;
            end
            m_cyc     <= m_cyc_nxt;
            m_we      <= m_we_nxt;
            m_strb    <= m_strb_nxt;
            m_addr    <= m_addr_nxt;
            m_data_o  <= m_data_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

`ifdef MMU_BUS_TIMEOUT_EN
    logic [31:0] wait_cnt;

    // Fires in the last waiting cycle; an ack in that same cycle takes priority
    // in the FSM, so the error flag is qualified by the absence of ack.
    assign timeout = m_cyc && !m_ack && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= (m_cyc && !m_ack) ? wait_cnt + 32'd1 : 32'd0;
            rsp_err  <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_bus_master.sv
// tb/tb_mmu_bus_master.sv - directed self-checking bench for mmu_bus_master
module tb_mmu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        m_cyc;
    logic        m_we;
    logic [3:0]  m_strb;
    logic [31:0] m_addr;
    logic [31:0] m_data_o;
    logic        m_ack = 1'b0;
    logic [31:0] m_data_i = '0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mmu_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_cyc     (m_cyc),
        .m_we      (m_we),
        .m_strb    (m_strb),
        .m_addr    (m_addr),
        .m_data_o  (m_data_o),
        .m_ack     (m_ack),
        .m_data_i  (m_data_i)
    );

    // Presents a request from a negedge, waits (bounded) for req_ready, and
    // returns at the negedge after acceptance (first BEAT0 cycle).
    task automatic send_req(input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!req_ready) $display("FAIL send_req_ready: req_ready=%0b after %0d cycles, want 1", req_ready, waited);
        else n_pass++;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Acks one beat from the current negedge; returns at the following negedge.
    task automatic ack_beat(input logic [31:0] data);
        m_ack    = 1'b1;
        m_data_i = data;
        @(posedge clk);
        @(negedge clk);
        m_ack    = 1'b0;
        m_data_i = '0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready); else n_pass++;
        n_checks++;
        if ({m_cyc, m_we, m_strb} !== 6'b0) $display("FAIL reset_bus_ctl: got %b want 000000", {m_cyc, m_we, m_strb}); else n_pass++;
        n_checks++;
        if ({m_addr, m_data_o} !== 64'd0) $display("FAIL reset_bus_data: got %h want 0", {m_addr, m_data_o}); else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, rsp_rdata}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_write();
        send_req(1'b1, 2'd2, 32'h8000_0004, 32'h0000_0001);
        n_checks++;
        if ({m_cyc, m_we, req_ready} !== 3'b110) $display("FAIL aw_ctl: cyc/we/ready=%b want 110", {m_cyc, m_we, req_ready}); else n_pass++;
        n_checks++;
        if (m_addr !== 32'h8000_0004 || m_strb !== 4'b1111 || m_data_o !== 32'h0000_0001)
            $display("FAIL aw_beat: addr=%h strb=%b data=%h want 80000004 1111 00000001", m_addr, m_strb, m_data_o);
        else n_pass++;
        ack_beat(32'h0);
        n_checks++;
        if ({m_cyc, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'd0)
            $display("FAIL aw_rsp: cyc/valid/err=%b rdata=%h want 010 00000000", {m_cyc, rsp_valid, rsp_err}, rsp_rdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL aw_idle: valid/ready=%b want 01", {rsp_valid, req_ready}); else n_pass++;
    endtask

    task automatic test_byte_write();
        send_req(1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB);
        n_checks++;
        if (m_addr !== 32'h0 || m_strb !== 4'b1000 || m_data_o !== 32'hAB00_0000)
            $display("FAIL bw_beat: addr=%h strb=%b data=%h want 00000000 1000 ab000000", m_addr, m_strb, m_data_o);
        else n_pass++;
        ack_beat(32'h0);
        n_checks++;
        if ({m_cyc, rsp_valid} !== 2'b01) $display("FAIL bw_rsp: cyc/valid=%b want 01", {m_cyc, rsp_valid}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_split_read();
        send_req(1'b0, 2'd2, 32'h0000_0002, 32'h0);
        n_checks++;
        if (m_cyc !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h0 || m_strb !== 4'b1100)
            $display("FAIL sr_beat0: cyc=%0b we=%0b addr=%h strb=%b want 1 0 00000000 1100", m_cyc, m_we, m_addr, m_strb);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (m_cyc !== 1'b1 || m_strb !== 4'b1100) $display("FAIL sr_hold: cyc=%0b strb=%b want 1 1100", m_cyc, m_strb); else n_pass++;
        ack_beat(32'h4433_2211);
        n_checks++;
        if ({m_cyc, rsp_valid} !== 2'b00) $display("FAIL sr_gap: cyc/valid=%b want 00", {m_cyc, rsp_valid}); else n_pass++;
        // ack and junk data while m_cyc is low must be ignored
        ack_beat(32'hFFFF_FFFF);
        n_checks++;
        if (m_cyc !== 1'b1 || rsp_valid !== 1'b0 || m_addr !== 32'h4 || m_strb !== 4'b0011)
            $display("FAIL sr_beat1: cyc=%0b valid=%0b addr=%h strb=%b want 1 0 00000004 0011", m_cyc, rsp_valid, m_addr, m_strb);
        else n_pass++;
        ack_beat(32'h8877_6655);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h6655_4433)
            $display("FAIL sr_rsp: valid=%0b rdata=%h want 1 66554433", rsp_valid, rsp_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_half_read();
        send_req(1'b0, 2'd1, 32'h0000_0001, 32'h0);
        n_checks++;
        if (m_addr !== 32'h0 || m_strb !== 4'b0110) $display("FAIL hr_beat: addr=%h strb=%b want 00000000 0110", m_addr, m_strb); else n_pass++;
        ack_beat(32'hDDCC_BBAA);
        n_checks++;
        if (m_cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_CCBB)
            $display("FAIL hr_rsp: cyc=%0b valid=%0b rdata=%h want 0 1 0000ccbb", m_cyc, rsp_valid, rsp_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int hi_cycles = 0;
        send_req(1'b0, 2'd2, 32'hC000_0000, 32'h0);
`ifdef MMU_BUS_TIMEOUT_EN
        while (m_cyc && hi_cycles < 50) begin
            hi_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (hi_cycles != 8) $display("FAIL to_cycles: m_cyc high %0d cycles want 8", hi_cycles); else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'd0)
            $display("FAIL to_rsp: valid/err=%b rdata=%h want 11 00000000", {rsp_valid, rsp_err}, rsp_rdata);
        else n_pass++;
        @(negedge clk);
        // ack in the very cycle the limit is reached wins
        send_req(1'b0, 2'd2, 32'hC000_0004, 32'h0);
        repeat (7) @(negedge clk);
        ack_beat(32'h1122_3344);
        n_checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1122_3344)
            $display("FAIL to_ackwin: valid/err=%b rdata=%h want 10 11223344", {rsp_valid, rsp_err}, rsp_rdata);
        else n_pass++;
`else
        repeat (20) begin
            if (m_cyc) hi_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (hi_cycles != 20 || m_cyc !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL to_wait: high=%0d cyc=%0b valid=%0b want 20 1 0", hi_cycles, m_cyc, rsp_valid);
        else n_pass++;
        ack_beat(32'h1234_5678);
        n_checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234_5678)
            $display("FAIL to_late_ack: valid/err=%b rdata=%h want 10 12345678", {rsp_valid, rsp_err}, rsp_rdata);
        else n_pass++;
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_split();
        int seen = 0;
        send_req(1'b1, 2'd1, 32'h0000_0003, 32'h0000_BEEF);
        n_checks++;
        if (m_strb !== 4'b1000 || m_data_o !== 32'hEF00_0000)
            $display("FAIL rs_beat0: strb=%b data=%h want 1000 ef000000", m_strb, m_data_o);
        else n_pass++;
        ack_beat(32'h0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_cyc, m_we, m_strb, rsp_valid, req_ready} !== 8'b0000_0001 || {m_addr, m_data_o} !== 64'd0)
            $display("FAIL rs_async: ctl=%b addr=%h data=%h want 00000001 0 0",
                     {m_cyc, m_we, m_strb, rsp_valid, req_ready}, m_addr, m_data_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || m_cyc) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL rs_quiet: %0d cycles with rsp_valid or m_cyc want 0", seen); else n_pass++;
        send_req(1'b0, 2'd2, 32'h0000_0008, 32'h0);
        n_checks++;
        if (m_addr !== 32'h8 || m_strb !== 4'b1111) $display("FAIL rs_new_beat: addr=%h strb=%b want 00000008 1111", m_addr, m_strb); else n_pass++;
        ack_beat(32'hCAFE_F00D);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D)
            $display("FAIL rs_new_rsp: valid=%0b rdata=%h want 1 cafef00d", rsp_valid, rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_req(1'b0, 2'd2, 32'h0000_0010, 32'h0);
        ack_beat(32'hAAAA_5555);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAAAA_5555)
            $display("FAIL b2b_rsp1: valid=%0b rdata=%h want 1 aaaa5555", rsp_valid, rsp_rdata);
        else n_pass++;
        // presented during RESP: must not be taken until the IDLE cycle
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h0000_0021;
        req_wdata = 32'h0000_005A;
        @(negedge clk);
        n_checks++;
        if ({req_ready, m_cyc, rsp_valid} !== 3'b100) $display("FAIL b2b_idle: ready/cyc/valid=%b want 100", {req_ready, m_cyc, rsp_valid}); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (m_cyc !== 1'b1 || m_addr !== 32'h20 || m_strb !== 4'b0010 || m_data_o !== 32'h0000_5A00)
            $display("FAIL b2b_beat2: cyc=%0b addr=%h strb=%b data=%h want 1 00000020 0010 00005a00", m_cyc, m_addr, m_strb, m_data_o);
        else n_pass++;
        ack_beat(32'h0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) $display("FAIL b2b_rsp2: valid=%0b rdata=%h want 1 00000000", rsp_valid, rsp_rdata); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_aligned_write();
        test_byte_write();
        test_split_read();
        test_half_read();
        test_timeout();
        test_reset_mid_split();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mmu_bus_master.md
# mmu_bus_master

Converts CPU/MMU memory requests (byte, halfword, word, any byte address) into single-beat transactions on the MMU master port of `wish_bus`, and returns the read data and completion status. Accesses that cross a 32-bit boundary are split into two bus beats, and the read data from both beats is merged. The block sits directly upstream of `wish_bus` and drives its `m_mmu_*` inputs. Main memory, the DMA registers (0x8000_000x) and the keyboard registers (0xC000_000x) are all reached through it.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of cycles to wait for ack per beat. Used only when the timeout feature is compiled in.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block accepts a request in this cycle; high only in IDLE.
- `req_we` in 1: 1 = write, 0 = read.
- `req_size` in 2: access size. 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data, right-aligned (LSB = lowest byte).
- `rsp_valid` out 1: one-cycle pulse when the request completes.
- `rsp_rdata` out 32: read data, right-aligned and zero-extended; 0 for writes.
- `rsp_err` out 1: the request timed out; valid with `rsp_valid`.
- `m_cyc`, `m_we` out 1: bus cycle request and write enable.
- `m_strb` out 4: byte lane enables.
- `m_addr` out 32: word address `{addr[31:2], 2'b00}`.
- `m_data_o` out 32: write data, shifted into the target byte lanes.
- `m_ack` in 1: slave ack, one cycle wide.
- `m_data_i` in 32: read data; valid when `m_ack` is high.

## Operation
States: IDLE, BEAT0, GAP, BEAT1, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, register we, size, addr and wdata, then go to BEAT0.
- **Per-beat setup**
  - o = `addr[1:0]`, n = number of bytes (1, 2 or 4).
  - BEAT0 lanes are o .. min(o+n-1, 3).
  - The access is split if o+n > 4. BEAT1 then addresses word+4, lanes 0 .. o+n-5.
- **Write data**
  - BEAT0: `m_data_o` = wdata << 8·o.
  - BEAT1: `m_data_o` = wdata >> 8·(4-o).
  - Disabled lanes are don't-care and are driven as 0.
- **BEAT0 / BEAT1**
  - `m_cyc` = 1 with registered address, strb, we and data held stable until `m_ack`.
  - On ack in BEAT0: if split, go to GAP; otherwise go to RESP.
  - On ack in BEAT1: go to RESP.
- **GAP**
  - `m_cyc` = 0 for exactly one cycle so the arbiter can re-arbitrate, then go to BEAT1.
- **Read merge**
  - Result byte i (i < n) comes from BEAT0 lane o+i when o+i < 4, else from BEAT1 lane o+i-4.
  - Bytes n..3 are 0.
  - Beat data is captured on ack.
- **RESP**
  - `rsp_valid` = 1 for one cycle, then go to IDLE. There is no response backpressure.
- **Ignored inputs**
  - `m_ack` while `m_cyc` = 0 has no effect.
  - `req_valid` outside IDLE has no effect.
- **Reset**
  - Asynchronous return to IDLE; the in-flight request is discarded and no `rsp_valid` is produced.
  - Reset values: all outputs 0, except `req_ready` = 1 (IDLE).

## Timing
- All bus outputs and `rsp_*` are registered.
- Request accepted at edge 0 → `m_cyc` high from cycle 1.
- Ack seen at cycle k → `m_cyc` low at k+1 and `rsp_valid` at k+1 (unsplit access).
- Split access: BEAT0 ack at k1 → GAP at k1+1 → BEAT1 `m_cyc` high from k1+2 → ack at k2 → `rsp_valid` at k2+1.
- Minimum latency (ack in the first cycle):
  - Aligned: 2 cycles from acceptance to `rsp_valid`.
  - Split: 4 cycles.
- Back-to-back: the next request can be accepted in the cycle after `rsp_valid`.

## Configuration
- `MMU_BUS_TIMEOUT_EN` defined:
  - A per-beat counter counts cycles with `m_cyc` = 1 and no ack.
  - When the count reaches `TIMEOUT_CYCLES`, the block drops `m_cyc`, skips any remaining beat, and goes to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - An ack arriving in the same cycle as the timeout wins; no error is reported.
- Not defined: no counter, `rsp_err` tied 0, and the block waits for ack indefinitely.

## Structure
- Package `mmu_bus_pkg` holds:
  - size encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`);
  - the state enum;
  - the default timeout constant.
- Sub-module `mmu_lane_gen` (combinational): takes offset, size and wdata and produces strb0/strb1, data0/data1 and the split flag.
- The read merge, FSM and timeout counter live in the top module.

## Test plan
- Aligned word write: addr 0x8000_0004, data 0x0000_0001 → one beat with addr 0x8000_0004, strb 1111, data_o 0x0000_0001; `rsp_valid` the cycle after ack.
- Byte write: addr 0x0000_0003, data 0x0000_00AB → addr 0x0, strb 1000, data_o 0xAB00_0000.
- Unaligned word read: addr 0x0000_0002, beat data 0x4433_2211 then 0x8877_6655 → two beats at 0x0 (strb 1100) and 0x4 (strb 0011), one GAP cycle with `m_cyc` = 0; `rsp_rdata` = 0x6655_4433.
- Halfword read at 0x0000_0001, slave data 0xDDCC_BBAA → single beat, strb 0110; `rsp_rdata` = 0x0000_CCBB.
- Timeout (macro on, `TIMEOUT_CYCLES` = 8), read of 0xC000_0000 with no ack:
  - `m_cyc` drops after 8 cycles;
  - `rsp_err` = 1 and `rsp_rdata` = 0;
  - with the macro off, `m_cyc` stays high.
- Reset asserted between the two beats of a split write:
  - all bus outputs go to 0 and `req_ready` = 1 immediately;
  - no `rsp_valid` appears;
  - a new aligned request completes normally after reset.
